// File: rtl/pipe_decode_control.sv
// ID stage register: decodes RV32I words into the EX control bundle.
// Adds illegal detection, optional M decode, load-use bubbles, flush.
module pipe_decode_control #(
   parameter int XLEN             = 32,
   parameter bit ENABLE_M         = 1'b0,
   parameter int LOAD_USE_BUBBLES = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            if_valid_i,
   output logic            if_ready_o,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            flush_i,
   input  logic            ex_ready_i,
   output logic            ex_valid_o,
   output logic [XLEN-1:0] ex_pc_o,
   output logic [31:0]     ex_inst_o,
   output logic [4:0]      ex_rs1_o,
   output logic [4:0]      ex_rs2_o,
   output logic [4:0]      ex_rd_o,
   output logic            ex_reg_write_o,
   output logic            ex_mem_write_o,
   output logic            ex_mem_to_reg_o,
   output logic            ex_branch_o,
   output logic            ex_jump_o,
   output logic            ex_jal_o,
   output logic            ex_lui_o,
   output logic            ex_auipc_o,
   output logic            ex_alu_src_o,
   output logic            ex_r_type_o,
   output logic            ex_mul_div_o,
   output logic            ex_illegal_o,
   output logic [1:0]      ex_alu_op_o
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [2:0] BUB_RELOAD = 3'(LOAD_USE_BUBBLES - 1);

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
      logic       jal;
      logic       lui;
      logic       auipc;
      logic       alu_src;
      logic       r_type;
      logic       mul_div;
      logic       illegal;
      logic [1:0] alu_op;
   } ctrl_t;

   ctrl_t            dec;
   ctrl_t            ctrl_q;
   logic             valid_q, valid_d;
   logic [2:0]       bub_q, bub_d;
   logic [XLEN-1:0]  pc_q;
   logic [31:0]      inst_q;
   logic             use_rs1, use_rs2;
   logic             hazard, accept;

   logic [6:0] op;
   logic [6:0] f7;
   logic [4:0] rs1, rs2;
   logic is_r, is_i, is_b, is_jal, is_jalr;
   logic is_ld, is_st, is_lui, is_auipc;
   logic f7_ok, bad;

   assign op       = inst_i[6:0];
   assign f7       = inst_i[31:25];
   assign rs1      = inst_i[19:15];
   assign rs2      = inst_i[24:20];
   assign is_r     = (op == OP_R);
   assign is_i     = (op == OP_I);
   assign is_b     = (op == OP_B);
   assign is_jal   = (op == OP_JAL);
   assign is_jalr  = (op == OP_JALR);
   assign is_ld    = (op == OP_LOAD);
   assign is_st    = (op == OP_STORE);
   assign is_lui   = (op == OP_LUI);
   assign is_auipc = (op == OP_AUIPC);

   assign f7_ok = (f7 == 7'b0000000) | (f7 == 7'b0100000)
                | (ENABLE_M & (f7 == 7'b0000001));

   assign bad = (op[1:0] != 2'b11)
              | ~(is_r | is_i | is_b | is_jal | is_jalr
                  | is_ld | is_st | is_lui | is_auipc)
              | (is_r & ~f7_ok);

   // Decode the incoming word; illegal words keep only their ALU class
   always_comb begin
      dec            = '0;
      dec.illegal    = bad;
      dec.r_type     = is_r;
      dec.alu_src    = ~(is_r | is_b);
      dec.reg_write  = ~bad & ~(is_b | is_st);
      dec.mem_write  = ~bad & is_st;
      dec.mem_to_reg = ~bad & is_ld;
      dec.branch     = ~bad & is_b;
      dec.jump       = ~bad & (is_jal | is_jalr);
      dec.jal        = ~bad & is_jal;
      dec.lui        = ~bad & is_lui;
      dec.auipc      = ~bad & is_auipc;
      dec.mul_div    = ~bad & is_r & ENABLE_M & (f7 == 7'b0000001);
      unique case (1'b1)
         is_r:    dec.alu_op = 2'b11;
         is_i:    dec.alu_op = 2'b01;
         is_b:    dec.alu_op = 2'b10;
         default: dec.alu_op = 2'b00;
      endcase
   end

   assign use_rs1 = ~bad & ~(is_lui | is_auipc | is_jal);
   assign use_rs2 = ~bad & (is_r | is_b | is_st);

   assign hazard = valid_q & ctrl_q.mem_to_reg & (inst_q[11:7] != 5'd0)
                 & if_valid_i
                 & ((use_rs1 & (rs1 == inst_q[11:7]))
                  | (use_rs2 & (rs2 == inst_q[11:7])));

   assign if_ready_o = ~flush_i & (bub_q == 3'd0) & ~hazard
                     & (~valid_q | ex_ready_i);
   assign accept = if_valid_i & if_ready_o;

   // Valid and bubble counter next state; flush wins over everything
   always_comb begin
      valid_d = valid_q;
      bub_d   = bub_q;
      if (flush_i) begin
         valid_d = 1'b0;
         bub_d   = 3'd0;
      end else if (bub_q != 3'd0) begin
         bub_d = bub_q - 3'd1;
      end else if (accept) begin
         valid_d = 1'b1;
      end else if (ex_ready_i) begin
         valid_d = 1'b0;
         if (hazard) bub_d = BUB_RELOAD;
      end
   end

   // Handshake state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         bub_q   <= 3'd0;
      end else begin
         valid_q <= valid_d;
         bub_q   <= bub_d;
      end
   end

   // Payload registers load only on accept
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q <= '0;
         pc_q   <= '0;
         inst_q <= '0;
      end else if (accept) begin
         ctrl_q <= dec;
         pc_q   <= pc_i;
         inst_q <= inst_i;
      end
   end

   assign ex_valid_o      = valid_q;
   assign ex_pc_o         = pc_q;
   assign ex_inst_o       = inst_q;
   assign ex_rs1_o        = inst_q[19:15];
   assign ex_rs2_o        = inst_q[24:20];
   assign ex_rd_o         = inst_q[11:7];
   assign ex_reg_write_o  = ctrl_q.reg_write;
   assign ex_mem_write_o  = ctrl_q.mem_write;
   assign ex_mem_to_reg_o = ctrl_q.mem_to_reg;
   assign ex_branch_o     = ctrl_q.branch;
   assign ex_jump_o       = ctrl_q.jump;
   assign ex_jal_o        = ctrl_q.jal;
   assign ex_lui_o        = ctrl_q.lui;
   assign ex_auipc_o      = ctrl_q.auipc;
   assign ex_alu_src_o    = ctrl_q.alu_src;
   assign ex_r_type_o     = ctrl_q.r_type;
   assign ex_mul_div_o    = ctrl_q.mul_div;
   assign ex_illegal_o    = ctrl_q.illegal;
   assign ex_alu_op_o     = ctrl_q.alu_op;

endmodule

// File: tb/tb_pipe_decode_control.sv
// Scoreboard bench for pipe_decode_control.
// Two instances: M decode on (a) and off (b), same stimulus.
module tb_pipe_decode_control;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, if_valid_i, flush_i, ex_ready_i;
   logic [31:0] inst_i, pc_i;

   logic        a_rdy, a_v, a_rw, a_mw, a_mtr, a_br, a_j, a_jal;
   logic        a_lui, a_au, a_as, a_r, a_md, a_il;
   logic [1:0]  a_op;
   logic [31:0] a_pc, a_inst;
   logic [4:0]  a_rs1, a_rs2, a_rd;

   logic        b_rdy, b_v, b_rw, b_mw, b_mtr, b_br, b_j, b_jal;
   logic        b_lui, b_au, b_as, b_r, b_md, b_il;
   logic [1:0]  b_op;
   logic [31:0] b_pc, b_inst;
   logic [4:0]  b_rs1, b_rs2, b_rd;

   logic [13:0] ca, cb;
   assign ca = {a_rw, a_mw, a_mtr, a_br, a_j, a_jal, a_lui, a_au,
                a_as, a_r, a_md, a_il, a_op};
   assign cb = {b_rw, b_mw, b_mtr, b_br, b_j, b_jal, b_lui, b_au,
                b_as, b_r, b_md, b_il, b_op};

   pipe_decode_control #(
      .XLEN(32), .ENABLE_M(1'b1), .LOAD_USE_BUBBLES(2)
   ) dut_a (
      .clk(clk), .reset_n(reset_n),
      .if_valid_i(if_valid_i), .if_ready_o(a_rdy),
      .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i),
      .ex_ready_i(ex_ready_i), .ex_valid_o(a_v),
      .ex_pc_o(a_pc), .ex_inst_o(a_inst),
      .ex_rs1_o(a_rs1), .ex_rs2_o(a_rs2), .ex_rd_o(a_rd),
      .ex_reg_write_o(a_rw), .ex_mem_write_o(a_mw),
      .ex_mem_to_reg_o(a_mtr), .ex_branch_o(a_br),
      .ex_jump_o(a_j), .ex_jal_o(a_jal), .ex_lui_o(a_lui),
      .ex_auipc_o(a_au), .ex_alu_src_o(a_as),
      .ex_r_type_o(a_r), .ex_mul_div_o(a_md),
      .ex_illegal_o(a_il), .ex_alu_op_o(a_op)
   );

   pipe_decode_control #(
      .XLEN(32), .ENABLE_M(1'b0), .LOAD_USE_BUBBLES(2)
   ) dut_b (
      .clk(clk), .reset_n(reset_n),
      .if_valid_i(if_valid_i), .if_ready_o(b_rdy),
      .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i),
      .ex_ready_i(ex_ready_i), .ex_valid_o(b_v),
      .ex_pc_o(b_pc), .ex_inst_o(b_inst),
      .ex_rs1_o(b_rs1), .ex_rs2_o(b_rs2), .ex_rd_o(b_rd),
      .ex_reg_write_o(b_rw), .ex_mem_write_o(b_mw),
      .ex_mem_to_reg_o(b_mtr), .ex_branch_o(b_br),
      .ex_jump_o(b_j), .ex_jal_o(b_jal), .ex_lui_o(b_lui),
      .ex_auipc_o(b_au), .ex_alu_src_o(b_as),
      .ex_r_type_o(b_r), .ex_mul_div_o(b_md),
      .ex_illegal_o(b_il), .ex_alu_op_o(b_op)
   );

   localparam logic [31:0] ADD    = 32'h002081B3;
   localparam logic [31:0] SUB    = 32'h402081B3;
   localparam logic [31:0] SW     = 32'h0020A023;
   localparam logic [31:0] BEQ    = 32'h00208063;
   localparam logic [31:0] JAL    = 32'h000000EF;
   localparam logic [31:0] LUI    = 32'h000012B7;
   localparam logic [31:0] BAD7   = 32'hFE2081B3;
   localparam logic [31:0] ZERO   = 32'h00000000;
   localparam logic [31:0] MUL    = 32'h022081B3;
   localparam logic [31:0] LW5    = 32'h0000A283;
   localparam logic [31:0] ADD65  = 32'h00028333;
   localparam logic [31:0] LW0    = 32'h0000A003;
   localparam logic [31:0] ADD600 = 32'h00000333;

   localparam logic [13:0] C_ADD  = 14'b1000_0000_0100_11;
   localparam logic [13:0] C_SW   = 14'b0100_0000_1000_00;
   localparam logic [13:0] C_LW   = 14'b1010_0000_1000_00;
   localparam logic [13:0] C_BEQ  = 14'b0001_0000_0000_10;
   localparam logic [13:0] C_JAL  = 14'b1000_1100_1000_00;
   localparam logic [13:0] C_LUI  = 14'b1000_0010_1000_00;
   localparam logic [13:0] C_BADR = 14'b0000_0000_0101_11;
   localparam logic [13:0] C_ZERO = 14'b0000_0000_1001_00;
   localparam logic [13:0] C_MUL1 = 14'b1000_0000_0110_11;
   localparam logic [13:0] C_MUL0 = 14'b0000_0000_0101_11;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [13:0] c;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   logic [13:0] ce_a, ce_b;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] ins, input logic [31:0] pc,
                          input logic [13:0] ea, input logic [13:0] eb);
      if_valid_i = 1'b1;
      inst_i     = ins;
      pc_i       = pc;
      ce_a       = ea;
      ce_b       = eb;
   endtask

   task automatic idle();
      if_valid_i = 1'b0;
   endtask

   // Record expectations for every word each instance accepts
   always @(negedge clk) begin
      if (reset_n && if_valid_i && a_rdy)
         qa.push_back('{pc: pc_i, inst: inst_i, c: ce_a});
      if (reset_n && if_valid_i && b_rdy)
         qb.push_back('{pc: pc_i, inst: inst_i, c: ce_b});
   end

   // Check every handoff into EX against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && a_v && ex_ready_i) begin
         if (qa.size() == 0) begin
            chk("a_unexpected", 64'(a_inst), 64'hFFFF_FFFF_FFFF);
         end else begin
            e = qa.pop_front();
            chk("a_ctrl", 64'(ca), 64'(e.c));
            chk("a_pc_inst", {a_pc, a_inst}, {e.pc, e.inst});
            chk("a_regs", {49'd0, a_rs1, a_rs2, a_rd},
                {49'd0, e.inst[19:15], e.inst[24:20], e.inst[11:7]});
         end
      end
      if (reset_n && b_v && ex_ready_i) begin
         if (qb.size() == 0) begin
            chk("b_unexpected", 64'(b_inst), 64'hFFFF_FFFF_FFFF);
         end else begin
            e = qb.pop_front();
            chk("b_ctrl", 64'(cb), 64'(e.c));
            chk("b_pc_inst", {b_pc, b_inst}, {e.pc, e.inst});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset_n    = 1'b0;
      if_valid_i = 1'b0;
      inst_i     = '0;
      pc_i       = '0;
      flush_i    = 1'b0;
      ex_ready_i = 1'b1;
      ce_a       = '0;
      ce_b       = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      chk("rst_valid", 64'(a_v), 64'd0);
      chk("rst_ctrl", 64'(ca), 64'd0);
      chk("rst_pc_inst", {a_pc, a_inst}, 64'd0);
      chk("rst_ready", 64'(a_rdy), 64'd1);

      // Back-to-back decode of distinct classes
      step();
      present(ADD, 32'h10, C_ADD, C_ADD);
      step();
      present(SW, 32'h14, C_SW, C_SW);
      @(negedge clk);
      chk("lat_valid", 64'(a_v), 64'd1);
      chk("lat_inst", 64'(a_inst), 64'(ADD));
      step();
      present(BEQ, 32'h18, C_BEQ, C_BEQ);
      step();
      present(JAL, 32'h1C, C_JAL, C_JAL);
      step();
      present(LUI, 32'h20, C_LUI, C_LUI);
      step();
      present(SUB, 32'h24, C_ADD, C_ADD);
      step();
      present(BAD7, 32'h28, C_BADR, C_BADR);
      step();
      present(ZERO, 32'h2C, C_ZERO, C_ZERO);
      step();
      idle();
      step();

      // Load-use with two bubbles
      present(LW5, 32'h100, C_LW, C_LW);
      step();
      present(ADD65, 32'h104, C_ADD, C_ADD);
      @(negedge clk);
      chk("lu_c1_ready", 64'(a_rdy), 64'd0);
      chk("lu_c1_valid", 64'(a_v), 64'd1);
      step();
      @(negedge clk);
      chk("lu_c2_ready", 64'(a_rdy), 64'd0);
      chk("lu_c2_valid", 64'(a_v), 64'd0);
      step();
      @(negedge clk);
      chk("lu_c3_ready", 64'(a_rdy), 64'd1);
      chk("lu_c3_valid", 64'(a_v), 64'd0);
      step();
      idle();
      @(negedge clk);
      chk("lu_c4_valid", 64'(a_v), 64'd1);
      chk("lu_c4_rd", 64'(a_rd), 64'd6);
      step();

      // x0 load never stalls
      present(LW0, 32'h120, C_LW, C_LW);
      step();
      present(ADD600, 32'h124, C_ADD, C_ADD);
      @(negedge clk);
      chk("x0_ready", 64'(a_rdy), 64'd1);
      chk("x0_valid1", 64'(a_v), 64'd1);
      step();
      idle();
      @(negedge clk);
      chk("x0_valid2", 64'(a_v), 64'd1);
      chk("x0_rd", 64'(a_rd), 64'd6);
      step();

      // M extension on vs off
      present(MUL, 32'h140, C_MUL1, C_MUL0);
      step();
      idle();
      @(negedge clk);
      chk("mul_a_muldiv", 64'(a_md), 64'd1);
      chk("mul_b_illegal", 64'(b_il), 64'd1);
      chk("mul_b_regwrite", 64'(b_rw), 64'd0);
      step();

      // Backpressure holds the register
      ex_ready_i = 1'b0;
      present(ADD, 32'h200, C_ADD, C_ADD);
      step();
      present(SUB, 32'h204, C_ADD, C_ADD);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_ready", 64'(a_rdy), 64'd0);
         chk("bp_valid", 64'(a_v), 64'd1);
         chk("bp_hold", {a_pc, a_inst}, {32'h200, ADD});
         chk("bp_ctrl", 64'(ca), 64'(C_ADD));
         step();
      end
      ex_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_release", 64'(a_rdy), 64'd1);
      step();
      idle();
      step();

      // Flush cancels a pending load-use countdown
      present(LW5, 32'h300, C_LW, C_LW);
      step();
      present(ADD65, 32'h304, C_ADD, C_ADD);
      flush_i = 1'b1;
      @(negedge clk);
      chk("fl_ready", 64'(a_rdy), 64'd0);
      step();
      flush_i = 1'b0;
      @(negedge clk);
      chk("fl_valid", 64'(a_v), 64'd0);
      chk("fl_ready_next", 64'(a_rdy), 64'd1);
      step();
      idle();
      @(negedge clk);
      chk("fl_dep_valid", 64'(a_v), 64'd1);
      chk("fl_dep_pc", 64'(a_pc), 64'h304);
      step();

      // Asynchronous reset while holding a valid word
      ex_ready_i = 1'b0;
      present(ADD, 32'h400, C_ADD, C_ADD);
      step();
      idle();
      @(negedge clk);
      chk("mr_pre_valid", 64'(a_v), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("mr_valid", 64'(a_v), 64'd0);
      chk("mr_ctrl", 64'(ca), 64'd0);
      chk("mr_pc_inst", {a_pc, a_inst}, 64'd0);
      qa.delete();
      qb.delete();
      @(negedge clk);
      reset_n    = 1'b1;
      ex_ready_i = 1'b1;
      @(negedge clk);
      chk("mr_ready", 64'(a_rdy), 64'd1);
      chk("mr_valid_after", 64'(a_v), 64'd0);
      step();
      present(LUI, 32'h500, C_LUI, C_LUI);
      step();
      idle();
      step();

      for (int i = 0; i < 20 && (qa.size() + qb.size()) != 0; i++)
         @(negedge clk);
      chk("drain", 64'(qa.size() + qb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
